voice_allocator: RTL and testbench
==================================

# voice_allocator

Assigns incoming note-on/note-off events to the eight voice slots of the harmonizer: one 7-bit note per slot, 0 = silent. Sits directly upstream of the harmonizer, between the score/MIDI-style event source and the organ synthesizer bank. It holds a slot table with per-slot age tracking. When all slots are busy it either drops the note-on or, if compiled in, steals the oldest voice.

## Interface
- NOTE_W, 7: note code width; code 0 means silence.
- AGE_W, 3: per-slot age counter width, saturating.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ev_valid  in  1  event offered.
- ev_ready  out  1  allocator can accept an event.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  NOTE_W  note code of the event.
- all_off  in  1  panic: silence every slot.
- note_out7..note_out0  out  NOTE_W each  slot notes, wired straight to the harmonizer note inputs.
- active  out  8  bit i = slot i holds a nonzero note.
- drop  out  1  one-cycle pulse: note-on discarded, table full.
- steal  out  1  one-cycle pulse: a voice was stolen. Tied 0 when stealing is compiled out.

## Operation
- Reset: all note_out = 0, active = 0, ages = 0, drop = steal = 0, state IDLE. ev_ready = 0 while rst is high.
- FSM states: IDLE → LOOKUP → UPDATE → IDLE.
  - IDLE: ev_ready = !all_off. On ev_valid & ev_ready, capture ev_on/ev_note and go to LOOKUP.
  - LOOKUP: scan the 8 slots and register three results: match index (slot == note), lowest free index (slot == 0), and oldest index (max age; ties go to the lowest index). Also register the found/free flags. Go to UPDATE.
  - UPDATE: apply the rule below and go to IDLE.
- Note-on, note ≠ 0:
  - Match found: retrigger. Slot note is unchanged, its age is set to 0, and every other occupied slot's age increments (saturating).
  - Otherwise, free slot found: write the note there with age 0 and age the other occupied slots.
  - Otherwise, table full: steal or drop (see Configuration).
- Note-on with note = 0 is ignored: no table change, no pulse.
- Note-off: if a match is found, write 0 to that slot and clear its age. No match = no-op. Other slots' ages are unchanged.
- A given note occupies at most one slot at any time.
- all_off is accepted in any state and has priority over rst-free operation. On the next edge: every slot and age = 0, the in-flight event is discarded, state goes to IDLE, and no drop/steal pulse is produced.
- Age arithmetic is unsigned AGE_W bits and saturates at 2^AGE_W−1, never wrapping.

## Timing
- Handshake accepted at edge E0. Lookup is registered at E1. note_out/active update and the drop/steal pulse fire at E2. ev_ready returns high after E2.
- Throughput: one event per 3 cycles. ev_ready stays low in LOOKUP and UPDATE.
- drop/steal are high for exactly the cycle after E2.
- Outputs are registered with no combinational path from ev_* to note_out.
- ev_valid held high with ev_ready low: the event is held, not consumed. The source must keep ev_on/ev_note stable until it sees ready.

## Configuration
- VOICE_STEAL_EN defined: a full-table note-on overwrites the oldest slot (lowest index on a tie), sets its age to 0, ages the others, and pulses steal.
- VOICE_STEAL_EN undefined: a full-table note-on leaves the table unchanged and pulses drop. The steal port stays and is tied 0.

## Structure
- Shared package holds:
  - state encoding (IDLE, LOOKUP, UPDATE);
  - NUM_VOICES = 8;
  - NOTE_SILENT = 0;
  - AGE_MAX.
- One sub-module, voice_pick: combinational scan of the slot/age arrays producing the match, free and oldest indices plus their flags. It is instantiated once and registered in LOOKUP.

## Test plan
- Reset, then note-on 60, 64, 67 → note_out0 = 60, note_out1 = 64, note_out2 = 67, active = 0x07; each event accepted 3 cycles apart.
- Note-off 64 → note_out1 = 0, active = 0x05. Next note-on 72 → lands in slot 1.
- Fill all 8 slots with 40..47, then note-on 50:
  - with VOICE_STEAL_EN: slot0 = 50, one steal pulse;
  - without it: table unchanged, one drop pulse.
- Retrigger 43 while full, then note-on 50 with VOICE_STEAL_EN → slot0 (age 7) is stolen, not slot3.
- Note-off 99 (absent) and note-on 0 → no change, no pulses, ev_ready back high after 3 cycles.
- Assert all_off during LOOKUP of note-on 55 → next cycle all note_out = 0, active = 0, state IDLE, 55 never appears.

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg
// Shared definitions for the voice allocator: widths, slot count, the
// silent note code, the age ceiling, FSM state encoding, the debug view
// of the FSM and the saturating age helper.
package voice_allocator_pkg;

  localparam int NUM_VOICES = 8;
  localparam int NOTE_W     = 7;
  localparam int AGE_W      = 3;
  localparam int IDX_W      = 3;

  localparam logic [NOTE_W-1:0] NOTE_SILENT = '0;
  localparam logic [AGE_W-1:0]  AGE_MAX     = '1;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  // Debug view: FSM state plus the registered lookup results.
  typedef struct packed {
    logic [1:0]       state;
    logic             match_found;
    logic             free_found;
    logic [IDX_W-1:0] match_idx;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] old_idx;
  } va_dbg_t;

  // Age increment that sticks at AGE_MAX instead of wrapping.
  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? a : a + 1'b1;
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// voice_allocator_if
// Event handshake between the score/MIDI event source and the allocator.
//   ev_valid  source -> allocator  event offered
//   ev_ready  allocator -> source  allocator can take an event
//   ev_on     source -> allocator  1 = note-on, 0 = note-off
//   ev_note   source -> allocator  note code (0 = silence)
// Handshake: an event transfers on a rising clock edge where ev_valid and
// ev_ready are both high. While ev_valid is high and ev_ready is low the
// source holds ev_on/ev_note stable; ev_ready never depends on ev_valid.
interface voice_allocator_if;
  import voice_allocator_pkg::*;

  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;

  modport master (output ev_valid, output ev_on, output ev_note, input ev_ready);
  modport slave  (input ev_valid, input ev_on, input ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator_pick.sv
// voice_pick
// Combinational scan of the slot table.
//   slot_i      slot notes
//   age_i       slot ages
//   note_i      note being looked up
//   match_*     lowest slot holding note_i (never matches the silent code)
//   free_*      lowest silent slot
//   old_idx     slot with the largest age, lowest index on a tie
module voice_pick
  import voice_allocator_pkg::*;
(
  input  logic [NOTE_W-1:0] slot_i [NUM_VOICES],
  input  logic [AGE_W-1:0]  age_i  [NUM_VOICES],
  input  logic [NOTE_W-1:0] note_i,
  output logic [IDX_W-1:0]  match_idx,
  output logic              match_found,
  output logic [IDX_W-1:0]  free_idx,
  output logic              free_found,
  output logic [IDX_W-1:0]  old_idx
);

  logic [AGE_W-1:0] old_age;

  always_comb begin
    match_idx   = '0;
    match_found = 1'b0;
    free_idx    = '0;
    free_found  = 1'b0;
    old_idx     = '0;
    old_age     = age_i[0];
    // Walk downwards so the last hit written is the lowest index.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (note_i != NOTE_SILENT && slot_i[i] == note_i) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
      if (slot_i[i] == NOTE_SILENT) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    // Strict greater-than keeps the earliest slot on equal ages.
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_i[i] > old_age) begin
        old_age = age_i[i];
        old_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator
// Assigns note-on/note-off events to eight voice slots with per-slot
// saturating age. A full-table note-on is dropped, or, when built with
// VOICE_STEAL_EN defined, replaces the oldest voice.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   all_off         panic: silence every slot on the next edge
//   ev              event handshake (slave side)
//   note_out0..7    slot notes
//   active          bit i set when slot i holds a nonzero note
//   drop            one-cycle pulse: note-on discarded, table full
//   steal           one-cycle pulse: a voice was stolen (0 without steal)
//   dbg             FSM state and registered lookup results
// One event takes three cycles: IDLE (accept) -> LOOKUP (register scan)
// -> UPDATE (write table, pulse) -> IDLE.
module voice_allocator
  import voice_allocator_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               all_off,
  voice_allocator_if.slave   ev,
  output logic [NOTE_W-1:0]  note_out0,
  output logic [NOTE_W-1:0]  note_out1,
  output logic [NOTE_W-1:0]  note_out2,
  output logic [NOTE_W-1:0]  note_out3,
  output logic [NOTE_W-1:0]  note_out4,
  output logic [NOTE_W-1:0]  note_out5,
  output logic [NOTE_W-1:0]  note_out6,
  output logic [NOTE_W-1:0]  note_out7,
  output logic [NUM_VOICES-1:0] active,
  output logic               drop,
  output logic               steal,
  output va_dbg_t            dbg
);

  logic [1:0]        state_q, state_d;
  logic              on_q, on_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [NOTE_W-1:0] slot_q [NUM_VOICES];
  logic [NOTE_W-1:0] slot_d [NUM_VOICES];
  logic [AGE_W-1:0]  age_q  [NUM_VOICES];
  logic [AGE_W-1:0]  age_d  [NUM_VOICES];
  logic [IDX_W-1:0]  match_idx_q, match_idx_d;
  logic [IDX_W-1:0]  free_idx_q, free_idx_d;
  logic [IDX_W-1:0]  old_idx_q, old_idx_d;
  logic              match_found_q, match_found_d;
  logic              free_found_q, free_found_d;
  logic              drop_q, drop_d;
  logic              ev_ready_w;

  logic [IDX_W-1:0]  pick_match_idx, pick_free_idx, pick_old_idx;
  logic              pick_match_found, pick_free_found;

  logic [IDX_W-1:0]  hit_idx;
  logic              age_others;

  voice_pick u_pick (
    .slot_i      (slot_q),
    .age_i       (age_q),
    .note_i      (note_q),
    .match_idx   (pick_match_idx),
    .match_found (pick_match_found),
    .free_idx    (pick_free_idx),
    .free_found  (pick_free_found),
    .old_idx     (pick_old_idx)
  );

  assign ev_ready_w  = (state_q == ST_IDLE) && !all_off && !rst;
  assign ev.ev_ready = ev_ready_w;

`ifdef VOICE_STEAL_EN
  logic steal_q, steal_d;
  assign steal = steal_q;
`else
  assign steal = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    on_d          = on_q;
    note_d        = note_q;
    slot_d        = slot_q;
    age_d         = age_q;
    match_idx_d   = match_idx_q;
    free_idx_d    = free_idx_q;
    old_idx_d     = old_idx_q;
    match_found_d = match_found_q;
    free_found_d  = free_found_q;
    drop_d        = 1'b0;
`ifdef VOICE_STEAL_EN
    steal_d       = 1'b0;
`endif
    hit_idx       = '0;
    age_others    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ev.ev_valid && ev_ready_w) begin
          on_d    = ev.ev_on;
          note_d  = ev.ev_note;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        match_idx_d   = pick_match_idx;
        match_found_d = pick_match_found;
        free_idx_d    = pick_free_idx;
        free_found_d  = pick_free_found;
        old_idx_d     = pick_old_idx;
        state_d       = ST_UPDATE;
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
        if (on_q && note_q != NOTE_SILENT) begin
          if (match_found_q) begin
            // Retrigger: the note stays where it is, only its age resets.
            hit_idx    = match_idx_q;
            age_others = 1'b1;
          end else if (free_found_q) begin
            slot_d[free_idx_q] = note_q;
            hit_idx    = free_idx_q;
            age_others = 1'b1;
          end else begin
`ifdef VOICE_STEAL_EN
            slot_d[old_idx_q] = note_q;
            hit_idx    = old_idx_q;
            age_others = 1'b1;
            steal_d    = 1'b1;
`else
            drop_d     = 1'b1;
`endif
          end
          if (age_others) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IDX_W'(i) != hit_idx && slot_q[i] != NOTE_SILENT) begin
                age_d[i] = age_inc(age_q[i]);
              end
            end
            age_d[hit_idx] = '0;
          end
        end else if (!on_q && match_found_q) begin
          slot_d[match_idx_q] = NOTE_SILENT;
          age_d[match_idx_q]  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Panic overrides whatever the FSM was doing, including the pulses.
    if (all_off) begin
      state_d = ST_IDLE;
      drop_d  = 1'b0;
`ifdef VOICE_STEAL_EN
      steal_d = 1'b0;
`endif
      for (int i = 0; i < NUM_VOICES; i++) begin
        slot_d[i] = NOTE_SILENT;
        age_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      on_q          <= 1'b0;
      note_q        <= NOTE_SILENT;
      match_idx_q   <= '0;
      free_idx_q    <= '0;
      old_idx_q     <= '0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      drop_q        <= 1'b0;
`ifdef VOICE_STEAL_EN
      steal_q       <= 1'b0;
`endif
      for (int i = 0; i < NUM_VOICES; i++) begin
        slot_q[i] <= NOTE_SILENT;
        age_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      on_q          <= on_d;
      note_q        <= note_d;
      match_idx_q   <= match_idx_d;
      free_idx_q    <= free_idx_d;
      old_idx_q     <= old_idx_d;
      match_found_q <= match_found_d;
      free_found_q  <= free_found_d;
      drop_q        <= drop_d;
`ifdef VOICE_STEAL_EN
      steal_q       <= steal_d;
`endif
      for (int i = 0; i < NUM_VOICES; i++) begin
        slot_q[i] <= slot_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  assign note_out0 = slot_q[0];
  assign note_out1 = slot_q[1];
  assign note_out2 = slot_q[2];
  assign note_out3 = slot_q[3];
  assign note_out4 = slot_q[4];
  assign note_out5 = slot_q[5];
  assign note_out6 = slot_q[6];
  assign note_out7 = slot_q[7];
  assign drop      = drop_q;

  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      active[i] = (slot_q[i] != NOTE_SILENT);
    end
  end

  always_comb begin
    dbg             = '0;
    dbg.state       = state_q;
    dbg.match_found = match_found_q;
    dbg.free_found  = free_found_q;
    dbg.match_idx   = match_idx_q;
    dbg.free_idx    = free_idx_q;
    dbg.old_idx     = old_idx_q;
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
// Self-checking bench for voice_allocator. The reference model keeps the
// slot table as plain integer arrays and applies the allocation rules
// directly. Expected drop/steal pulses go through a scoreboard queue.
// Build with VOICE_STEAL_EN defined to check the stealing variant.
module tb_voice_allocator;
  import voice_allocator_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic all_off = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  voice_allocator_if ev_if ();

  logic [6:0] no0, no1, no2, no3, no4, no5, no6, no7;
  logic [7:0] active;
  logic       drop, steal;
  va_dbg_t    dbg;
  logic [6:0] n_out [8];

  assign n_out[0] = no0;
  assign n_out[1] = no1;
  assign n_out[2] = no2;
  assign n_out[3] = no3;
  assign n_out[4] = no4;
  assign n_out[5] = no5;
  assign n_out[6] = no6;
  assign n_out[7] = no7;

  voice_allocator dut (
    .clk       (clk),
    .rst       (rst),
    .all_off   (all_off),
    .ev        (ev_if),
    .note_out0 (no0),
    .note_out1 (no1),
    .note_out2 (no2),
    .note_out3 (no3),
    .note_out4 (no4),
    .note_out5 (no5),
    .note_out6 (no6),
    .note_out7 (no7),
    .active    (active),
    .drop      (drop),
    .steal     (steal),
    .dbg       (dbg)
  );

  // ---------------- reference model / scoreboard ----------------
  int m_slot [8];
  int m_age  [8];
  logic [1:0] exp_q[$];   // {drop, steal} expected after each event
  int checks = 0;
  int fails  = 0;
  int last_acc = 0;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_slot[i] = 0;
      m_age[i]  = 0;
    end
  endtask

  task automatic model_apply(input logic on, input int note);
    int m, f, o, tgt;
    logic d, s;
    m = -1; f = -1; o = 0; tgt = -1; d = 1'b0; s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (note != 0 && m_slot[i] == note && m < 0) m = i;
      if (m_slot[i] == 0 && f < 0) f = i;
      if (m_age[i] > m_age[o]) o = i;
    end
    if (on && note != 0) begin
      if (m >= 0) tgt = m;
      else if (f >= 0) begin
        tgt = f;
        m_slot[f] = note;
      end else begin
`ifdef VOICE_STEAL_EN
        tgt = o;
        m_slot[o] = note;
        s = 1'b1;
`else
        d = 1'b1;
`endif
      end
      if (tgt >= 0) begin
        for (int i = 0; i < 8; i++)
          if (i != tgt && m_slot[i] != 0) m_age[i] = (m_age[i] >= 7) ? 7 : m_age[i] + 1;
        m_age[tgt] = 0;
      end
    end else if (!on && m >= 0) begin
      m_slot[m] = 0;
      m_age[m]  = 0;
    end
    exp_q.push_back({d, s});
  endtask

  task automatic check_table(input string tag);
    logic [7:0] exp_act;
    exp_act = '0;
    for (int i = 0; i < 8; i++) begin
      exp_act[i] = (m_slot[i] != 0);
      checks++;
      if (n_out[i] !== 7'(m_slot[i])) begin
        fails++;
        $display("FAIL %s note_out%0d got %0d expected %0d", tag, i, n_out[i], m_slot[i]);
      end
    end
    checks++;
    if (active !== exp_act) begin
      fails++;
      $display("FAIL %s active got %h expected %h", tag, active, exp_act);
    end
  endtask

  // ---------------- driver ----------------
  // Starts and ends right after a falling edge.
  task automatic do_event(input logic on, input logic [6:0] note, input string tag);
    int w;
    logic [1:0] e;
    w = 0;
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on    = on;
    ev_if.ev_note  = note;
    #1;
    while (ev_if.ev_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    checks++;
    if (ev_if.ev_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_timeout got %b expected 1", tag, ev_if.ev_ready);
      ev_if.ev_valid = 1'b0;
      @(negedge clk);
      return;
    end
    @(posedge clk);            // E0: accepted
    model_apply(on, int'(note));
    @(negedge clk);
    last_acc = cyc;
    ev_if.ev_valid = 1'b0;
    checks++;
    if (ev_if.ev_ready !== 1'b0 || drop !== 1'b0 || steal !== 1'b0) begin
      fails++;
      $display("FAIL %s after_E0 ready/drop/steal got %b%b%b expected 000", tag, ev_if.ev_ready, drop, steal);
    end
    @(negedge clk);            // after E1
    checks++;
    if (ev_if.ev_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s after_E1 ready got %b expected 0", tag, ev_if.ev_ready);
    end
    @(negedge clk);            // after E2: table and pulse visible
    check_table(tag);
    e = exp_q.pop_front();
    checks++;
    if ({drop, steal} !== e) begin
      fails++;
      $display("FAIL %s pulse drop/steal got %b%b expected %b", tag, drop, steal, e);
    end
    checks++;
    if (ev_if.ev_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s after_E2 ready got %b expected 1", tag, ev_if.ev_ready);
    end
  endtask

  task automatic panic(input string tag);
    all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0;
    model_clear();
    check_table(tag);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ev_if.ev_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset ready_in_rst got %b expected 0", ev_if.ev_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    model_clear();
    check_table("reset");
    checks++;
    if (drop !== 1'b0 || steal !== 1'b0 || dbg.state !== ST_IDLE || ev_if.ev_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset drop/steal/state/ready got %b %b %0d %b expected 0 0 %0d 1",
               drop, steal, dbg.state, ev_if.ev_ready, ST_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    do_event(1'b1, 7'd60, "b2b_60");
    t0 = last_acc;
    do_event(1'b1, 7'd64, "b2b_64");
    checks++;
    if (last_acc - t0 != 3) begin
      fails++;
      $display("FAIL b2b spacing got %0d expected 3", last_acc - t0);
    end
    t0 = last_acc;
    do_event(1'b1, 7'd67, "b2b_67");
    checks++;
    if (last_acc - t0 != 3) begin
      fails++;
      $display("FAIL b2b spacing2 got %0d expected 3", last_acc - t0);
    end
    checks++;
    if (no0 !== 7'd60 || no1 !== 7'd64 || no2 !== 7'd67 || active !== 8'h07) begin
      fails++;
      $display("FAIL b2b table got %0d %0d %0d %h expected 60 64 67 07", no0, no1, no2, active);
    end
  endtask

  task automatic test_note_off();
    do_event(1'b0, 7'd64, "off_64");
    checks++;
    if (no1 !== 7'd0 || active !== 8'h05) begin
      fails++;
      $display("FAIL off_64 slot1/active got %0d %h expected 0 05", no1, active);
    end
    do_event(1'b1, 7'd72, "on_72");
    checks++;
    if (no1 !== 7'd72) begin
      fails++;
      $display("FAIL on_72 slot1 got %0d expected 72", no1);
    end
  endtask

  task automatic test_noop();
    do_event(1'b0, 7'd99, "off_99");
    do_event(1'b1, 7'd0, "on_0");
  endtask

  task automatic fill_40_47();
    panic("fill_clear");
    for (int n = 40; n < 48; n++) do_event(1'b1, 7'(n), "fill");
    checks++;
    if (active !== 8'hFF) begin
      fails++;
      $display("FAIL fill active got %h expected ff", active);
    end
  endtask

  task automatic test_full();
    logic [6:0] exp0;
    logic [1:0] exp_pulse;
    fill_40_47();
    do_event(1'b1, 7'd50, "full_50");
`ifdef VOICE_STEAL_EN
    exp0 = 7'd50;
    exp_pulse = 2'b01;
`else
    exp0 = 7'd40;
    exp_pulse = 2'b10;
`endif
    checks++;
    if (no0 !== exp0 || {drop, steal} !== exp_pulse) begin
      fails++;
      $display("FAIL full_50 slot0/pulse got %0d %b%b expected %0d %b", no0, drop, steal, exp0, exp_pulse);
    end
    @(negedge clk);
    checks++;
    if (drop !== 1'b0 || steal !== 1'b0) begin
      fails++;
      $display("FAIL full_50 pulse_width got %b%b expected 00", drop, steal);
    end
  endtask

  task automatic test_retrigger_steal();
    fill_40_47();
    do_event(1'b1, 7'd43, "retrig_43");
    do_event(1'b1, 7'd50, "steal_50");
`ifdef VOICE_STEAL_EN
    checks++;
    if (no0 !== 7'd50 || no3 !== 7'd43) begin
      fails++;
      $display("FAIL steal_oldest slot0/slot3 got %0d %0d expected 50 43", no0, no3);
    end
`else
    checks++;
    if (no0 !== 7'd40 || no3 !== 7'd43 || drop !== 1'b1) begin
      fails++;
      $display("FAIL drop_full slot0/slot3/drop got %0d %0d %b expected 40 43 1", no0, no3, drop);
    end
`endif
  endtask

  task automatic test_all_off_lookup();
    panic("aol_clear");
    do_event(1'b1, 7'd20, "aol_20");
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on    = 1'b1;
    ev_if.ev_note  = 7'd55;
    @(posedge clk);            // E0
    @(negedge clk);
    ev_if.ev_valid = 1'b0;
    checks++;
    if (dbg.state !== ST_LOOKUP) begin
      fails++;
      $display("FAIL aol state_before got %0d expected %0d", dbg.state, ST_LOOKUP);
    end
    all_off = 1'b1;
    @(negedge clk);
    model_clear();
    check_table("aol_cleared");
    checks++;
    if (dbg.state !== ST_IDLE || drop !== 1'b0 || steal !== 1'b0 || ev_if.ev_ready !== 1'b0) begin
      fails++;
      $display("FAIL aol state/drop/steal/ready got %0d %b %b %b expected %0d 0 0 0",
               dbg.state, drop, steal, ev_if.ev_ready, ST_IDLE);
    end
    all_off = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_table("aol_after");
      checks++;
      if (drop !== 1'b0 || steal !== 1'b0) begin
        fails++;
        $display("FAIL aol_after pulse got %b%b expected 00", drop, steal);
      end
    end
  endtask

  task automatic test_hold();
    do_event(1'b1, 7'd30, "hold_pre");
    all_off = 1'b1;
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on    = 1'b1;
    ev_if.ev_note  = 7'd31;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ev_if.ev_ready !== 1'b0 || dbg.state !== ST_IDLE) begin
        fails++;
        $display("FAIL hold ready/state got %b %0d expected 0 %0d", ev_if.ev_ready, dbg.state, ST_IDLE);
      end
    end
    all_off = 1'b0;
    model_clear();
    check_table("hold_cleared");
    do_event(1'b1, 7'd31, "hold_post");
  endtask

  task automatic test_random();
    logic on;
    logic [6:0] note;
    panic("rand_clear");
    for (int k = 0; k < 120; k++) begin
      on   = ($urandom_range(0, 3) != 0);
      note = 7'($urandom_range(0, 12));
      do_event(on, note, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    ev_if.ev_valid = 1'b0;
    ev_if.ev_on    = 1'b0;
    ev_if.ev_note  = '0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_note_off();
    test_noop();
    test_full();
    test_retrigger_steal();
    test_all_off_lookup();
    test_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
